// File: rtl/fetch_queue_unit.sv
// Instruction fetch front end: icache lookup or byte-serial memory fetch, next-PC
// predecode with a bimodal BHT, and a circular queue drained by dispatch.
module fetch_queue_unit #(
    parameter int          QUEUE_LOG2     = 4,
    parameter int          BHT_LOG2       = 6,
    parameter int          PREDICT_BRANCH = 1,
    parameter logic [31:0] RESET_PC       = 32'h0
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  flush_in,
    input  logic [31:0]           flush_pc_in,
    input  logic                  bht_upd_valid_in,
    input  logic [31:0]           bht_upd_pc_in,
    input  logic                  bht_upd_taken_in,
    output logic                  mem_req_out,
    output logic [31:0]           mem_addr_out,
    input  logic                  mem_grant_in,
    input  logic [7:0]            mem_din,
    output logic [31:0]           ic_lookup_pc_out,
    input  logic                  ic_hit_in,
    input  logic [31:0]           ic_instr_in,
    output logic                  ic_fill_valid_out,
    output logic [31:0]           ic_fill_pc_out,
    output logic [31:0]           ic_fill_instr_out,
    input  logic                  deq_ready_in,
    output logic                  deq_valid_out,
    output logic [31:0]           deq_instr_out,
    output logic [31:0]           deq_pc_out,
    output logic [31:0]           deq_pred_pc_out,
    output logic                  deq_pred_taken_out,
    output logic [QUEUE_LOG2:0]   count_out
);

    localparam int DEPTH   = 1 << QUEUE_LOG2;
    localparam int ENTRIES = 1 << BHT_LOG2;

    typedef enum logic {LOOKUP, FETCH} state_t;

    state_t                state;
    logic [31:0]           pc;
    logic [2:0]            req_idx;
    logic [1:0]            rcv_idx;
    logic                  grant_q;
    logic [23:0]           byte_buf;
    logic [QUEUE_LOG2-1:0] head;
    logic [QUEUE_LOG2-1:0] tail;
    logic [QUEUE_LOG2:0]   count;
    logic                  fill_valid_q;
    logic [31:0]           fill_pc_q;
    logic [31:0]           fill_instr_q;
    logic [1:0]            bht [ENTRIES];

    logic [31:0]           q_instr   [DEPTH];
    logic [31:0]           q_pc      [DEPTH];
    logic [31:0]           q_pred_pc [DEPTH];
    logic                  q_taken   [DEPTH];

    logic                  full;
    logic                  lookup_hit;
    logic                  lane3_done;
    logic                  push_en;
    logic                  pop_en;
    logic [31:0]           cand_word;
    logic [31:0]           j_imm;
    logic [31:0]           b_imm;
    logic [1:0]            bht_rd;
    logic [31:0]           pred_pc;
    logic                  pred_taken;
    logic [BHT_LOG2-1:0]   upd_idx;
    logic                  unused_upd_pc;

    assign full       = count[QUEUE_LOG2];
    assign lookup_hit = (state == LOOKUP) && ic_hit_in && !full;
    assign lane3_done = (state == FETCH) && grant_q && (rcv_idx == 2'd3);
    assign push_en    = rdy_in && !flush_in && (lookup_hit || lane3_done);
    assign pop_en     = rdy_in && !flush_in && deq_valid_out && deq_ready_in;

    // The candidate word is whatever would be pushed this cycle: the icache
    // hit data in LOOKUP, or the three buffered bytes plus the live byte.
    assign cand_word = (state == LOOKUP) ? ic_instr_in : {mem_din, byte_buf};
    assign j_imm     = {{11{cand_word[31]}}, cand_word[31], cand_word[19:12],
                        cand_word[20], cand_word[30:21], 1'b0};
    assign b_imm     = {{19{cand_word[31]}}, cand_word[31], cand_word[7],
                        cand_word[30:25], cand_word[11:8], 1'b0};
    assign bht_rd    = bht[pc[BHT_LOG2+1:2]];
    assign upd_idx   = bht_upd_pc_in[BHT_LOG2+1:2];
    assign unused_upd_pc = ^{bht_upd_pc_in[31:BHT_LOG2+2], bht_upd_pc_in[1:0]};

    always_comb begin
        pred_pc    = pc + 32'd4;
        pred_taken = 1'b0;
        if (cand_word[6:0] == 7'b1101111) begin
            pred_pc    = pc + j_imm;
            pred_taken = 1'b1;
        end else if (cand_word[6:0] == 7'b1100011 && PREDICT_BRANCH != 0 && bht_rd[1]) begin
            pred_pc    = pc + b_imm;
            pred_taken = 1'b1;
        end
    end

    assign ic_lookup_pc_out   = pc;
    assign mem_req_out        = rdy_in && (state == FETCH) && !req_idx[2];
    assign mem_addr_out       = (state == FETCH) ? pc + {29'd0, req_idx} : 32'd0;
    // A fill pulse caught by a freeze is held and emitted once rdy returns.
    assign ic_fill_valid_out  = fill_valid_q && rdy_in;
    assign ic_fill_pc_out     = fill_pc_q;
    assign ic_fill_instr_out  = fill_instr_q;
    assign deq_valid_out      = (count != '0);
    assign deq_instr_out      = deq_valid_out ? q_instr[head]   : 32'd0;
    assign deq_pc_out         = deq_valid_out ? q_pc[head]      : 32'd0;
    assign deq_pred_pc_out    = deq_valid_out ? q_pred_pc[head] : 32'd0;
    assign deq_pred_taken_out = deq_valid_out && q_taken[head];
    assign count_out          = count;

    always_ff @(posedge clk_in) begin
        if (push_en) begin
            q_instr[tail]   <= cand_word;
            q_pc[tail]      <= pc;
            q_pred_pc[tail] <= pred_pc;
            q_taken[tail]   <= pred_taken;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state        <= LOOKUP;
            pc           <= RESET_PC;
            req_idx      <= 3'd0;
            rcv_idx      <= 2'd0;
            grant_q      <= 1'b0;
            byte_buf     <= 24'd0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            fill_valid_q <= 1'b0;
            fill_pc_q    <= 32'd0;
            fill_instr_q <= 32'd0;
            for (int i = 0; i < ENTRIES; i++) bht[i] <= 2'b01;
        end else if (rdy_in) begin
            fill_valid_q <= 1'b0;
            // Commit-side training proceeds regardless of flush.
            if (bht_upd_valid_in) begin
                if (bht_upd_taken_in && bht[upd_idx] != 2'b11)
                    bht[upd_idx] <= bht[upd_idx] + 2'd1;
                else if (!bht_upd_taken_in && bht[upd_idx] != 2'b00)
                    bht[upd_idx] <= bht[upd_idx] - 2'd1;
            end
            if (flush_in) begin
                state   <= LOOKUP;
                pc      <= flush_pc_in;
                req_idx <= 3'd0;
                rcv_idx <= 2'd0;
                grant_q <= 1'b0;
                head    <= '0;
                tail    <= '0;
                count   <= '0;
            end else begin
                if (push_en) tail <= tail + QUEUE_LOG2'(1);
                if (pop_en)  head <= head + QUEUE_LOG2'(1);
                case ({push_en, pop_en})
                    2'b10:   count <= count + (QUEUE_LOG2+1)'(1);
                    2'b01:   count <= count - (QUEUE_LOG2+1)'(1);
                    default: count <= count;
                endcase
                case (state)
                    LOOKUP: begin
                        if (!full) begin
                            if (ic_hit_in) begin
                                pc <= pred_pc;
                            end else begin
                                state   <= FETCH;
                                req_idx <= 3'd0;
                                rcv_idx <= 2'd0;
                                grant_q <= 1'b0;
                            end
                        end
                    end
                    FETCH: begin
                        if (mem_grant_in && !req_idx[2]) req_idx <= req_idx + 3'd1;
                        grant_q <= mem_grant_in && mem_req_out;
                        if (grant_q) begin
                            rcv_idx <= rcv_idx + 2'd1;
                            case (rcv_idx)
                                2'd0:    byte_buf[7:0]   <= mem_din;
                                2'd1:    byte_buf[15:8]  <= mem_din;
                                2'd2:    byte_buf[23:16] <= mem_din;
                                default: begin
                                    fill_valid_q <= 1'b1;
                                    fill_pc_q    <= pc;
                                    fill_instr_q <= cand_word;
                                    pc           <= pred_pc;
                                    state        <= LOOKUP;
                                end
                            endcase
                        end
                    end
                    default: state <= LOOKUP;
                endcase
            end
        end
    end

endmodule
